spi_slave_rf: RTL and testbench
===============================

# spi_slave_rf

SPI mode-0 (CPOL=0, CPHA=0) responder clocked entirely from the system clock. It oversamples SCLK/CSN/MOSI through synchronizers, shifts bytes MSB-first in both directions, and exchanges one byte per 8 SCLK periods with the local logic through a byte-level handshake. It is the far end of the on-board SPI master link and supports both per-byte CSN toggling and multi-byte bursts with CSN held low.

## Interface
- SYNC_STAGES, 2, synchronizer depth on sclk/csn/mosi (>=2)
- DEFAULT_TX, 8'hFF, byte shifted out when no tx data is offered (underrun)
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset, asynchronous, active-low
- sclk  in  1  SPI clock from master, asynchronous to clk
- csn  in  1  chip select from master, active-low
- mosi  in  1  master-out data
- miso  out  1  slave-out data
- miso_oe  out  1  1 while the frame is active (csn low); tri-state enable for pad
- tx_byte  in  8  next byte to transmit
- tx_valid  in  1  tx_byte is valid (level, held until tx_ack)
- tx_ack  out  1  1-cycle pulse: tx_byte captured into shifter
- tx_underrun  out  1  1-cycle pulse: DEFAULT_TX loaded because tx_valid was 0
- rx_byte  out  8  last completed received byte
- rx_valid  out  1  1-cycle pulse: rx_byte updated
- frame_start  out  1  1-cycle pulse on detected CSN fall
- frame_end  out  1  1-cycle pulse on detected CSN rise
- frame_abort  out  1  1-cycle pulse: CSN rose with 1..7 bits of a byte received
- busy  out  1  1 while in SHIFT

## Operation
- Synchronizers: each input passes through SYNC_STAGES flops; edge detection compares last stage with one further registered copy. Reset values: sclk chain 0, csn chain 1, mosi chain 0.
- Arming: `armed` cleared by reset, set on any cycle with synced csn=1. A CSN fall is accepted only when armed (a frame already in progress at reset release is ignored until CSN deasserts).
- States: IDLE, SHIFT.
- IDLE: miso=0, miso_oe=0, busy=0. On accepted CSN fall: load shifter (see Load), bit_cnt=7, frame_start pulse, -> SHIFT.
- Load: if tx_valid then sh_tx=tx_byte and tx_ack pulse; else sh_tx=DEFAULT_TX and tx_underrun pulse. miso=new bit 7 on the same edge.
- SHIFT, synced SCLK rise: sh_rx={sh_rx[6:0],mosi_s}; if bit_cnt==0: rx_byte={sh_rx[6:0],mosi_s}, rx_valid pulse, set byte_done; else bit_cnt-1.
- SHIFT, synced SCLK fall: if byte_done: Load, bit_cnt=7, clear byte_done; else sh_tx shifts left and miso=next bit.
- SHIFT, synced CSN rise: -> IDLE, frame_end pulse; if bit_cnt!=7 and byte_done=0 also frame_abort pulse. Partial rx bits discarded (no rx_valid). The rising-CSN check has priority over any SCLK edge in the same cycle.
- A byte loaded on the 8th falling edge is consumed (tx_ack issued) even if CSN then rises; the producer treats tx_ack as consumption.
- Producer rule: after tx_ack, tx_valid must be deasserted or tx_byte updated on the next cycle.

## Timing
- Reset (rst=0): state IDLE, miso=0, miso_oe=0, rx_byte=8'h00, all pulses 0, busy=0, bit_cnt=7, shifters 0, armed=0.
- Pin-to-action latency: SYNC_STAGES+1 clk edges after the first clk edge sampling the new pin level. For SYNC_STAGES=2, miso and miso_oe become valid 3 cycles after CSN fall is first sampled. rx_valid follows the 8th SCLK rise by the same latency.
- Constraint: each SCLK half-period and the CSN-fall-to-first-SCLK-rise interval are >= SYNC_STAGES+4 clk cycles (master DIV=50 gives 50).
- All status outputs are single-cycle pulses; rx_byte holds until the next completed byte.

## Test plan
- Single byte, hold_csn=0, tx_byte=8'hA5 valid: master sends 8'h3C -> master receives 8'hA5; rx_valid once with rx_byte=8'h3C; one tx_ack, frame_start, frame_end; no abort.
- Burst of 3 bytes, CSN held: slave offers 8'h11,8'h22,8'h33 on successive acks; master sends 8'h01,8'h02,8'h03 -> master receives 11,22,33; three rx_valid pulses with 01,02,03 in order; one frame_start/frame_end; 4th tx_ack at the last fall.
- Underrun: tx_valid=0 -> master receives 8'hFF; tx_underrun pulse; rx still correct.
- Abort: CSN raised after 4 SCLK rises -> frame_abort and frame_end pulse, no rx_valid, rx_byte unchanged; next full frame with 8'h5A received correctly.
- Reset mid-frame: rst low during bit 3, released with CSN still low -> no frame_start, miso_oe=0 until CSN rises; the following frame passes 8'hC3 both ways.

Source files
------------

// File: rtl/spi_slave_rf.sv
`timescale 1ns/1ps
// spi_slave_rf: SPI mode-0 responder running entirely on the system clock.
// SCLK/CSN/MOSI are oversampled through synchronizers. Bytes are shifted
// MSB-first in both directions, and a byte-level handshake moves them to and
// from local logic.
// Ports:
//   clk, rst                 system clock, async active-low reset
//   sclk, csn, mosi          SPI pins from the master (asynchronous)
//   miso, miso_oe            slave data out and pad tri-state enable
//   tx_byte/tx_valid/tx_ack  transmit byte handshake (tx_underrun when starved)
//   rx_byte/rx_valid         last completed received byte and update pulse
//   frame_start/end/abort    frame event pulses
//   busy                     high while a frame is being shifted
module spi_slave_rf #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       csn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ack,
  output logic       tx_underrun,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_abort,
  output logic       busy
);

  localparam int unsigned MSB_IDX = SYNC_STAGES - 1;
  localparam logic [2:0]  BIT_TOP = 3'd7;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync, vld_sync;
  logic sclk_d, csn_d;
  logic sclk_s, csn_s, mosi_s, vld_s;
  logic sclk_rise, sclk_fall, csn_rise, csn_fall;

  state_t     state_q, state_d;
  logic [7:0] sh_tx_q, sh_tx_d, sh_rx_q, sh_rx_d, rx_byte_d, load_byte;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d, armed_q, armed_d;
  logic       miso_d, oe_d, tx_ack_d, tx_underrun_d, rx_valid_d;
  logic       frame_start_d, frame_end_d, frame_abort_d;

  // Pin synchronizers plus one extra copy for edge detection. vld_sync marks
  // when the csn chain holds real pin samples rather than reset values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      vld_sync  <= '0;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_sync[MSB_IDX];
      csn_d     <= csn_sync[MSB_IDX];
    end
  end

  assign sclk_s    = sclk_sync[MSB_IDX];
  assign csn_s     = csn_sync[MSB_IDX];
  assign mosi_s    = mosi_sync[MSB_IDX];
  assign vld_s     = vld_sync[MSB_IDX];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign csn_rise  = csn_s & ~csn_d;
  assign csn_fall  = ~csn_s & csn_d;
  assign load_byte = tx_valid ? tx_byte : DEFAULT_TX;

  // State and datapath registers; every output is a registered copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sh_tx_q     <= 8'h00;
      sh_rx_q     <= 8'h00;
      bit_cnt_q   <= BIT_TOP;
      byte_done_q <= 1'b0;
      armed_q     <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      rx_byte     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_ack      <= 1'b0;
      tx_underrun <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_tx_q     <= sh_tx_d;
      sh_rx_q     <= sh_rx_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      armed_q     <= armed_d;
      miso        <= miso_d;
      miso_oe     <= oe_d;
      busy        <= oe_d;
      rx_byte     <= rx_byte_d;
      rx_valid    <= rx_valid_d;
      tx_ack      <= tx_ack_d;
      tx_underrun <= tx_underrun_d;
      frame_start <= frame_start_d;
      frame_end   <= frame_end_d;
      frame_abort <= frame_abort_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    sh_tx_d       = sh_tx_q;
    sh_rx_d       = sh_rx_q;
    bit_cnt_d     = bit_cnt_q;
    byte_done_d   = byte_done_q;
    armed_d       = armed_q | (csn_s & vld_s);
    miso_d        = miso;
    rx_byte_d     = rx_byte;
    rx_valid_d    = 1'b0;
    tx_ack_d      = 1'b0;
    tx_underrun_d = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_abort_d = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        // A frame already running when reset released is ignored until CSN
        // has been seen high.
        if (csn_fall && armed_q) begin
          sh_tx_d       = load_byte;
          miso_d        = load_byte[7];
          tx_ack_d      = tx_valid;
          tx_underrun_d = ~tx_valid;
          bit_cnt_d     = BIT_TOP;
          byte_done_d   = 1'b0;
          frame_start_d = 1'b1;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        // CSN deassertion wins over any SCLK edge seen in the same cycle.
        if (csn_rise) begin
          state_d       = IDLE;
          frame_end_d   = 1'b1;
          frame_abort_d = (bit_cnt_q != BIT_TOP) && !byte_done_q;
          miso_d        = 1'b0;
          bit_cnt_d     = BIT_TOP;
          byte_done_d   = 1'b0;
        end else if (sclk_rise) begin
          sh_rx_d = {sh_rx_q[6:0], mosi_s};
          if (bit_cnt_q == 3'd0) begin
            rx_byte_d   = {sh_rx_q[6:0], mosi_s};
            rx_valid_d  = 1'b1;
            byte_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end else if (sclk_fall) begin
          if (byte_done_q) begin
            sh_tx_d       = load_byte;
            miso_d        = load_byte[7];
            tx_ack_d      = tx_valid;
            tx_underrun_d = ~tx_valid;
            bit_cnt_d     = BIT_TOP;
            byte_done_d   = 1'b0;
          end else begin
            sh_tx_d = {sh_tx_q[6:0], 1'b0};
            miso_d  = sh_tx_q[6];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    oe_d = (state_d == SHIFT);
  end

endmodule

// File: tb/tb_spi_slave_rf.sv
`timescale 1ns/1ps
// tb_spi_slave_rf: directed bench for spi_slave_rf. A bit-banged SPI master
// drives the pins, a queue-based producer answers tx_ack, and a monitor
// counts the single-cycle status pulses.
module tb_spi_slave_rf;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       csn = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ack, tx_underrun;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_start, frame_end, frame_abort, busy;

  int checks = 0;
  int errors = 0;

  int n_ack = 0, n_und = 0, n_rxv = 0, n_fs = 0, n_fe = 0, n_fa = 0, n_oe = 0;
  int b_ack, b_und, b_rxv, b_fs, b_fe, b_fa, b_oe;
  logic [7:0] rx_log [0:63];
  logic [7:0] tx_q [$];
  logic [7:0] mi;

  spi_slave_rf #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .csn(csn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ack(tx_ack),
    .tx_underrun(tx_underrun), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_start(frame_start), .frame_end(frame_end),
    .frame_abort(frame_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  // Producer and pulse monitor, sampled 1 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_ack && tx_q.size() > 0) void'(tx_q.pop_front());
      n_ack += int'(tx_ack);
      n_und += int'(tx_underrun);
      n_fs  += int'(frame_start);
      n_fe  += int'(frame_end);
      n_fa  += int'(frame_abort);
      n_oe  += int'(miso_oe);
      if (rx_valid) begin
        rx_log[n_rxv[5:0]] = rx_byte;
        n_rxv++;
      end
      tx_valid = (tx_q.size() > 0);
      tx_byte  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic snap();
    b_ack = n_ack; b_und = n_und; b_rxv = n_rxv; b_fs = n_fs;
    b_fe = n_fe; b_fa = n_fa; b_oe = n_oe;
  endtask

  task automatic csn_fall();
    csn = 1'b0;
    tick(HALF);
  endtask

  task automatic csn_rise();
    tick(HALF);
    csn = 1'b1;
    tick(2 * HALF);
  endtask

  // Mode-0 master: data set while SCLK low, MISO sampled at the rising edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7 - i];
      tick(HALF);
      sclk = 1'b1;
      rd = {rd[6:0], miso};
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    tick(4);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_oe", 32'(miso_oe), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rx_byte", 32'(rx_byte), 32'h00);
    chk("rst_tx_ack", 32'(tx_ack), 32'h0);
    rst = 1'b1;
    tick(10);

    // Single byte, CSN toggled per byte
    tx_q.push_back(8'hA5);
    tick(2);
    snap();
    csn_fall();
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_oe", 32'(miso_oe), 32'h1);
    xfer(8'h3C, 8, mi);
    csn_rise();
    chk("t1_mi", 32'(mi), 32'hA5);
    chk("t1_rx_byte", 32'(rx_byte), 32'h3C);
    chk("t1_rxv", 32'(n_rxv - b_rxv), 32'd1);
    chk("t1_rx_log", 32'(rx_log[b_rxv]), 32'h3C);
    chk("t1_ack", 32'(n_ack - b_ack), 32'd1);
    chk("t1_und", 32'(n_und - b_und), 32'd1);
    chk("t1_fs", 32'(n_fs - b_fs), 32'd1);
    chk("t1_fe", 32'(n_fe - b_fe), 32'd1);
    chk("t1_fa", 32'(n_fa - b_fa), 32'd0);
    chk("t1_idle_oe", 32'(miso_oe), 32'h0);

    // Burst of three bytes with CSN held low
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    tx_q.push_back(8'h44);
    tick(2);
    snap();
    csn_fall();
    xfer(8'h01, 8, mi);
    chk("t2_mi0", 32'(mi), 32'h11);
    xfer(8'h02, 8, mi);
    chk("t2_mi1", 32'(mi), 32'h22);
    xfer(8'h03, 8, mi);
    chk("t2_mi2", 32'(mi), 32'h33);
    csn_rise();
    chk("t2_rxv", 32'(n_rxv - b_rxv), 32'd3);
    chk("t2_rx0", 32'(rx_log[b_rxv]), 32'h01);
    chk("t2_rx1", 32'(rx_log[b_rxv + 1]), 32'h02);
    chk("t2_rx2", 32'(rx_log[b_rxv + 2]), 32'h03);
    chk("t2_ack", 32'(n_ack - b_ack), 32'd4);
    chk("t2_und", 32'(n_und - b_und), 32'd0);
    chk("t2_fs", 32'(n_fs - b_fs), 32'd1);
    chk("t2_fe", 32'(n_fe - b_fe), 32'd1);

    // Underrun: nothing offered
    snap();
    csn_fall();
    xfer(8'h96, 8, mi);
    csn_rise();
    chk("t3_mi", 32'(mi), 32'hFF);
    chk("t3_und", 32'(n_und - b_und), 32'd2);
    chk("t3_ack", 32'(n_ack - b_ack), 32'd0);
    chk("t3_rx_byte", 32'(rx_byte), 32'h96);

    // Abort after four SCLK rises
    tx_q.push_back(8'h77);
    tick(2);
    snap();
    csn_fall();
    xfer(8'hF0, 4, mi);
    csn_rise();
    chk("t4_fa", 32'(n_fa - b_fa), 32'd1);
    chk("t4_fe", 32'(n_fe - b_fe), 32'd1);
    chk("t4_rxv", 32'(n_rxv - b_rxv), 32'd0);
    chk("t4_rx_byte", 32'(rx_byte), 32'h96);
    chk("t4_ack", 32'(n_ack - b_ack), 32'd1);
    tx_q.push_back(8'hE7);
    tick(2);
    snap();
    csn_fall();
    xfer(8'h5A, 8, mi);
    csn_rise();
    chk("t4b_mi", 32'(mi), 32'hE7);
    chk("t4b_rx_byte", 32'(rx_byte), 32'h5A);
    chk("t4b_fa", 32'(n_fa - b_fa), 32'd0);

    // Reset during bit 3, released with CSN still low
    tx_q.push_back(8'h12);
    tick(2);
    csn_fall();
    xfer(8'hFF, 3, mi);
    rst = 1'b0;
    tick(3);
    chk("t5_rst_miso", 32'(miso), 32'h0);
    chk("t5_rst_oe", 32'(miso_oe), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_rx_byte", 32'(rx_byte), 32'h00);
    rst = 1'b1;
    tick(1);
    snap();
    xfer(8'h00, 5, mi);
    tick(HALF);
    chk("t5_fs", 32'(n_fs - b_fs), 32'd0);
    chk("t5_oe", 32'(n_oe - b_oe), 32'd0);
    chk("t5_rxv", 32'(n_rxv - b_rxv), 32'd0);
    chk("t5_busy", 32'(busy), 32'h0);
    csn_rise();
    tx_q.push_back(8'hC3);
    tick(2);
    snap();
    csn_fall();
    xfer(8'hC3, 8, mi);
    csn_rise();
    chk("t5b_mi", 32'(mi), 32'hC3);
    chk("t5b_rx_byte", 32'(rx_byte), 32'hC3);
    chk("t5b_fs", 32'(n_fs - b_fs), 32'd1);
    chk("t5b_rxv", 32'(n_rxv - b_rxv), 32'd1);
    chk("t5b_ack", 32'(n_ack - b_ack), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
